ram_burst_master: RTL
=====================

# ram_burst_master

Burst initiator for one port of the team's 512x8 dual-port RAM. It accepts a host command (start address, length, direction) through a valid/ready handshake. It then drives the RAM port signals (address, write data, write enable, read enable) and either streams write data from the host into the RAM or streams read data back to the host with full backpressure. The read path absorbs the RAM's one-cycle synchronous read latency and the RAM's held output register.

## Interface
- ADDR_W, 10, RAM address width
- DATA_W, 8, data width
- DEPTH, 512, number of valid RAM words; addresses >= DEPTH are illegal
- LEN_W, 10, burst length width; legal lengths are 1..DEPTH
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  word count
- wr_valid  in  1  write word offered
- wr_ready  out  1  high only in WRITE
- wr_data  in  DATA_W  write word
- rd_valid  out  1  read buffer head valid
- rd_ready  in  1  host accepts read word
- rd_data  out  DATA_W  read buffer head
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_wren  out  1  registered write strobe
- ram_rden  out  1  registered read strobe
- ram_q  in  DATA_W  RAM read data, valid the cycle after ram_rden
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, burst complete
- err  out  1  one-cycle pulse, command rejected

## Operation
- States: IDLE, WRITE, READ.
- Command acceptance:
  - A command is accepted when cmd_valid and cmd_ready are high together.
  - Command checks use an (ADDR_W+1)-bit sum.
  - Reject if cmd_len == 0, or cmd_addr >= DEPTH, or cmd_addr + cmd_len > DEPTH.
  - On reject: err=1 in the next cycle, state stays IDLE, no RAM strobe, no done.
  - On accept: latch the address and length, then enter WRITE or READ.
- WRITE:
  - wr_ready=1.
  - Each wr handshake registers ram_addr=cur, ram_wdata=wr_data, ram_wren=1 for the following cycle, then cur increments.
  - After the last handshake, return to IDLE.
  - ram_wren is 0 in every cycle not following a handshake.
- READ:
  - 4-entry read FIFO.
  - Each cycle, issue a read (ram_rden=1, ram_addr=cur next cycle) while issued < len and occupancy + in-flight < 4.
  - in-flight counts strobes whose data has not yet been captured.
  - ram_q is captured into the FIFO exactly one cycle after each ram_rden=1 cycle. ram_q is never sampled otherwise, because the RAM holds q_a/q_b.
  - rd_valid = FIFO non-empty; rd_data = head.
  - Return to IDLE after len rd handshakes.
- Address never wraps; the range check guarantees cur < DEPTH.
- ram_wren and ram_rden are never high in the same cycle.
- Reset (asserted asynchronously, any time, including mid-burst):
  - State goes to IDLE and the FIFO is flushed.
  - All registered outputs go to 0: ram_*, rd_valid, done, err, busy.
  - cmd_ready=1 once rst is high.
  - Partially written words stay in the RAM.

## Timing
- Write:
  - Handshake in cycle N gives ram_wren in N+1.
  - Last handshake in N gives done=1 and busy=0 in N+1, alongside the final ram_wren.
  - A new command may be accepted in N+1; its first RAM strobe is no earlier than N+2.
- Read latency:
  - cmd handshake in C0 gives ram_rden in C1, capture at the end of C2, and rd_valid in C3.
  - With rd_ready held high: 1 word/cycle; a len-word burst finishes its last rd handshake at C(2+len).
- Read completion: last rd handshake in N gives done=1 and busy=0 in N+1.
- Backpressure: with rd_ready low, at most 4 reads are outstanding and no FIFO overflow occurs. rd_data and rd_valid are held stable until handshake.
- err is asserted in the cycle after the rejected handshake; cmd_ready stays 1.

## Test plan
- Write then read, no stall:
  - Stimulus: write addr=0x010, len=4, data A0..A3. Then read addr=0x010, len=4 with rd_ready=1.
  - Response: ram_wren on 4 consecutive cycles at addr 0x010..0x013. rd_data A0,A1,A2,A3 on 4 consecutive cycles, first word 3 cycles after cmd handshake. Exactly one done per burst.
- Read backpressure:
  - Stimulus: read len=8 with rd_ready low for 10 cycles, then high.
  - Response: ram_rden asserted exactly 4 times before rd_ready rises. Then 8 words in order, no loss or duplicate.
- Boundary:
  - Stimulus: cmd_addr=0x1FF, len=1 (write 5A, then read).
  - Response: accepted and 5A returned.
  - Stimulus: cmd_addr=0x1FF, len=2; cmd_addr=0x200, len=1; len=0.
  - Response: each gives err for one cycle, no strobe, busy stays 0.
- Write stall:
  - Stimulus: write len=3 with wr_valid gapped 1-0-0-1-1.
  - Response: exactly 3 ram_wren pulses, each one cycle after its handshake. done in the cycle of the third.
- Reset mid-read:
  - Stimulus: rst asserted in the middle of a len=16 read after 5 words.
  - Response: all outputs 0 immediately, FIFO empty, cmd_ready=1. A fresh read of the same region afterwards returns the correct data.

Source files
------------

// File: rtl/ram_burst_master.sv
// Burst initiator for one port of the 512x8 dual-port RAM: host command in, RAM strobes out,
// write data streamed in, read data streamed back through a 4-entry FIFO with backpressure.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_WRITE | accepting host words, one RAM write per wr handshake
// ST_READ  | issuing RAM reads and draining the read FIFO to the host
module ram_burst_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t            state, state_nxt;
    logic              cmd_fire, cmd_bad, wr_fire, rd_fire, issue;
    logic [ADDR_W:0]   cmd_end;
    logic [ADDR_W-1:0] cur;
    logic [LEN_W-1:0]  xfer_left, issue_left;
    logic              rden_q;
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr, rd_ptr;
    logic [2:0]        fifo_cnt;
    logic [2:0]        pending;

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        wr_ready  = (state == ST_WRITE);
        busy      = (state != ST_IDLE);
        rd_valid  = (fifo_cnt != 3'd0);
        rd_data   = rd_valid ? fifo_mem[rd_ptr] : '0;
        cmd_end   = {1'b0, cmd_addr} + (ADDR_W+1)'(cmd_len);
        cmd_bad   = (cmd_len == '0) || ({1'b0, cmd_addr} >= DEPTH_X) || (cmd_end > DEPTH_X);
        cmd_fire  = cmd_valid && cmd_ready;
        wr_fire   = wr_valid && wr_ready;
        rd_fire   = rd_valid && rd_ready;
        // FIFO words plus reads still travelling through the RAM must never exceed 4
        pending   = fifo_cnt + 3'(ram_rden) + 3'(rden_q);
        issue     = (state == ST_READ) && (issue_left != '0) && (pending < 3'd4);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire && !cmd_bad)
                    state_nxt = cmd_write ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                if (wr_fire && xfer_left == LEN_W'(1))
                    state_nxt = ST_IDLE;
            end
            ST_READ: begin
                if (rd_fire && xfer_left == LEN_W'(1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wren   <= 1'b0;
            ram_rden   <= 1'b0;
            rden_q     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cur        <= '0;
            xfer_left  <= '0;
            issue_left <= '0;
        end else begin
            ram_wren <= 1'b0;
            ram_rden <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rden_q   <= ram_rden;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else if (cmd_write) begin
                            cur        <= cmd_addr;
                            xfer_left  <= cmd_len;
                            issue_left <= '0;
                        end else begin
                            // first read goes out straight from the accept cycle
                            ram_rden   <= 1'b1;
                            ram_addr   <= cmd_addr;
                            cur        <= cmd_addr + ADDR_W'(1);
                            xfer_left  <= cmd_len;
                            issue_left <= cmd_len - LEN_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        ram_wren  <= 1'b1;
                        ram_addr  <= cur;
                        ram_wdata <= wr_data;
                        cur       <= cur + ADDR_W'(1);
                        xfer_left <= xfer_left - LEN_W'(1);
                        if (xfer_left == LEN_W'(1))
                            done <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        ram_rden   <= 1'b1;
                        ram_addr   <= cur;
                        cur        <= cur + ADDR_W'(1);
                        issue_left <= issue_left - LEN_W'(1);
                    end
                    if (rd_fire) begin
                        xfer_left <= xfer_left - LEN_W'(1);
                        if (xfer_left == LEN_W'(1))
                            done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ram_q is taken only the cycle after a strobe; the RAM holds q otherwise
    always_ff @(posedge clk) begin
        if (rden_q)
            fifo_mem[wr_ptr] <= ram_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rden_q)
                wr_ptr <= wr_ptr + 2'd1;
            if (rd_fire)
                rd_ptr <= rd_ptr + 2'd1;
            case ({rden_q, rd_fire})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
